dmem_axi_write: RTL and testbench

Store-path adapter that converts single-word core memory-bus write requests into AXI4 single-beat write transactions on the master write channels (AW/W/B), which are currently tied off. It sits beside the instruction-fetch read adapter, translates core addresses by the boot-programmed DRAM base, and reports completion back to the core once the write response arrives. One write is outstanding at a time.

---
 rtl/dmem_axi_write.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_axi_write.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_axi_write.sv
// ---------------------------------------------------------------------------
// dmem_axi_write
//
// Store-path adapter. It turns single-word core write requests into AXI4
// single-beat write transactions on the AW/W/B channels and reports
// completion back to the core once the write response has arrived. Only one
// write is in flight at a time.
//
// Optional feature macro: DMEM_AXI_WRITE_ERRSTAT_EN
//   defined     -> err_sticky / err_count track SLVERR/DECERR responses
//   not defined -> err_sticky / err_count tied to 0, no error logic
//
// Ports
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   dram_base                base added to mem_addr to form AWADDR
//   mem_valid / mem_ready    core store request handshake
//   mem_addr/wdata/wstrb     core store address, data, byte enables
//   mem_bdone                one-cycle pulse: store completed
//   M_AXI_AW*                write address channel (constant attributes)
//   M_AXI_W*                 write data channel, always a single last beat
//   M_AXI_B*                 write response channel
//   err_sticky, err_count    error status (see macro above)
// ---------------------------------------------------------------------------
module dmem_axi_write #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [31:0]           dram_base,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_bdone,
    output logic [AXI_ID_W-1:0]   M_AXI_AWID,
    output logic [AXI_ADDR_W-1:0] M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWLOCK,
    output logic [3:0]            M_AXI_AWCACHE,
    output logic [2:0]            M_AXI_AWPROT,
    output logic [3:0]            M_AXI_AWQOS,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [AXI_DATA_W-1:0] M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [AXI_ID_W-1:0]   M_AXI_BID,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic                  err_sticky,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [AXI_ADDR_W-1:0]   r_awaddr;
    logic [AXI_ADDR_W-1:0]   w_awaddrNext;
    logic [AXI_DATA_W-1:0]   r_wdata;
    logic [AXI_DATA_W-1:0]   w_wdataNext;
    logic [3:0]              r_wstrb;
    logic [3:0]              w_wstrbNext;
    logic                    r_awvalid;
    logic                    w_awvalidNext;
    logic                    r_wvalid;
    logic                    w_wvalidNext;
    logic                    r_bready;
    logic                    w_breadyNext;
    logic                    r_bdone;
    logic                    w_bdoneNext;
    logic [31:0]             w_sum;
    logic                    w_bHandshake;
    logic                    w_unused;

    // Address translation wraps modulo 2^32; low two bits are dropped so the
    // beat is always word aligned and byte lanes come from the strobes.
    assign w_sum        = dram_base + mem_addr;
    assign w_bHandshake = (r_state == RESP) && r_bready && M_AXI_BVALID;
    assign w_unused     = ^{M_AXI_BID, M_AXI_BRESP, w_sum[1:0]};

    // Next-state and next-output decode. VALIDs drop independently after
    // their own handshake; a VALID that is already low counts as done, so
    // the move to RESP happens once both are (or are about to be) low.
    always_comb begin
        w_stateNext   = r_state;
        w_awaddrNext  = r_awaddr;
        w_wdataNext   = r_wdata;
        w_wstrbNext   = r_wstrb;
        w_awvalidNext = r_awvalid;
        w_wvalidNext  = r_wvalid;
        w_breadyNext  = r_bready;
        w_bdoneNext   = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_valid) begin
                    if (mem_wstrb == 4'h0) begin
                        w_bdoneNext = 1'b1;
                    end else begin
                        w_awaddrNext  = AXI_ADDR_W'({w_sum[31:2], 2'b00});
                        w_wdataNext   = AXI_DATA_W'(mem_wdata);
                        w_wstrbNext   = mem_wstrb;
                        w_awvalidNext = 1'b1;
                        w_wvalidNext  = 1'b1;
                        w_stateNext   = SEND;
                    end
                end
            end
            SEND: begin
                w_awvalidNext = r_awvalid && !M_AXI_AWREADY;
                w_wvalidNext  = r_wvalid && !M_AXI_WREADY;
                if (!w_awvalidNext && !w_wvalidNext) begin
                    w_breadyNext = 1'b1;
                    w_stateNext  = RESP;
                end
            end
            RESP: begin
                if (w_bHandshake) begin
                    w_breadyNext = 1'b0;
                    w_bdoneNext  = 1'b1;
                    w_stateNext  = IDLE;
                end
            end
            default: begin
                w_awvalidNext = 1'b0;
                w_wvalidNext  = 1'b0;
                w_breadyNext  = 1'b0;
                w_stateNext   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight write.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= IDLE;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_bdone   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_awaddr  <= w_awaddrNext;
            r_wdata   <= w_wdataNext;
            r_wstrb   <= w_wstrbNext;
            r_awvalid <= w_awvalidNext;
            r_wvalid  <= w_wvalidNext;
            r_bready  <= w_breadyNext;
            r_bdone   <= w_bdoneNext;
        end
    end

`ifdef DMEM_AXI_WRITE_ERRSTAT_EN
    logic       r_errSticky;
    logic [7:0] r_errCount;

    // SLVERR and DECERR both have BRESP[1] set; the counter saturates.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_errSticky <= 1'b0;
            r_errCount  <= 8'd0;
        end else if (w_bHandshake && M_AXI_BRESP[1]) begin
            r_errSticky <= 1'b1;
            if (r_errCount != 8'hFF) begin
                r_errCount <= r_errCount + 8'd1;
            end
        end
    end

    assign err_sticky = r_errSticky;
    assign err_count  = r_errCount;
`else
    assign err_sticky = 1'b0;
    assign err_count  = 8'd0;
`endif

    assign mem_ready     = (r_state == IDLE);
    assign mem_bdone     = r_bdone;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WLAST   = r_wvalid;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;

endmodule

// File: tb/tb_dmem_axi_write.sv
// ---------------------------------------------------------------------------
// tb_dmem_axi_write
//
// Directed bench for dmem_axi_write. Inputs change and outputs are observed
// 1 time unit after each rising ACLK edge. Compile with or without
// DMEM_AXI_WRITE_ERRSTAT_EN to match the design build.
// ---------------------------------------------------------------------------
module tb_dmem_axi_write;

    logic        ACLK;
    logic        ARESETN;
    logic [31:0] dram_base;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_bdone;
    logic [0:0]  M_AXI_AWID;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWLOCK;
    logic [3:0]  M_AXI_AWCACHE;
    logic [2:0]  M_AXI_AWPROT;
    logic [3:0]  M_AXI_AWQOS;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [0:0]  M_AXI_BID;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic        err_sticky;
    logic [7:0]  err_count;

    int total;
    int bad;

    dmem_axi_write dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .dram_base(dram_base),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_bdone(mem_bdone),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR),
        .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
        .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWQOS(M_AXI_AWQOS), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA),
        .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .err_sticky(err_sticky), .err_count(err_count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic nextCycle();
        @(posedge ACLK);
        #1;
    endtask

    // Presents one store with all AXI readies high and a response waiting;
    // returns in the cycle where mem_bdone should be high (accept + 3).
    task automatic runStore(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        mem_addr      = addr;
        mem_wdata     = data;
        mem_wstrb     = strb;
        mem_valid     = 1'b1;
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        M_AXI_BRESP   = resp;
        M_AXI_BVALID  = 1'b1;
        nextCycle();
        mem_valid = 1'b0;
        nextCycle();
        nextCycle();
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        #20;
        total++; if (mem_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got %b want 1", mem_ready); end
        total++; if (mem_bdone !== 1'b0) begin bad++; $display("[TB] FAIL reset_bdone got %b want 0", mem_bdone); end
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b000) begin bad++; $display("[TB] FAIL reset_valids got %b want 000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}); end
        total++; if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB} !== 68'h0) begin bad++; $display("[TB] FAIL reset_payload got %h want 0", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB}); end
        total++; if ({err_sticky, err_count} !== 9'h0) begin bad++; $display("[TB] FAIL reset_err got %h want 0", {err_sticky, err_count}); end
        @(negedge ACLK);
        ARESETN = 1'b1;
        nextCycle();
    endtask

    task automatic test_basic();
        dram_base     = 32'h1000_0000;
        mem_addr      = 32'h0000_0040;
        mem_wdata     = 32'hDEAD_BEEF;
        mem_wstrb     = 4'hF;
        mem_valid     = 1'b1;
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        M_AXI_BVALID  = 1'b1;
        nextCycle();
        mem_valid = 1'b0;
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, mem_ready} !== 5'b11100) begin bad++; $display("[TB] FAIL basic_c1_ctrl got %b want 11100", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, mem_ready}); end
        total++; if (M_AXI_AWADDR !== 32'h1000_0040) begin bad++; $display("[TB] FAIL basic_awaddr got %h want 10000040", M_AXI_AWADDR); end
        total++; if ({M_AXI_WDATA, M_AXI_WSTRB} !== {32'hDEAD_BEEF, 4'hF}) begin bad++; $display("[TB] FAIL basic_wpayload got %h want deadbeeff", {M_AXI_WDATA, M_AXI_WSTRB}); end
        total++; if ({M_AXI_AWID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS} !== {1'b0, 8'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0}) begin bad++; $display("[TB] FAIL basic_awattr got %h", {M_AXI_AWID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS}); end
        nextCycle();
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, mem_bdone} !== 4'b0010) begin bad++; $display("[TB] FAIL basic_c2 got %b want 0010", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, mem_bdone}); end
        nextCycle();
        M_AXI_BVALID = 1'b0;
        total++; if ({mem_bdone, mem_ready, M_AXI_BREADY} !== 3'b110) begin bad++; $display("[TB] FAIL basic_c3_done got %b want 110", {mem_bdone, mem_ready, M_AXI_BREADY}); end
        nextCycle();
        total++; if (mem_bdone !== 1'b0) begin bad++; $display("[TB] FAIL basic_c4_pulse got %b want 0", mem_bdone); end
    endtask

    task automatic test_aw_delay();
        mem_addr      = 32'h0000_0100;
        mem_wdata     = 32'hCAFE_F00D;
        mem_wstrb     = 4'h3;
        mem_valid     = 1'b1;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b1;
        M_AXI_BVALID  = 1'b1;
        nextCycle();
        mem_valid = 1'b0;
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b11) begin bad++; $display("[TB] FAIL awdly_c1 got %b want 11", {M_AXI_AWVALID, M_AXI_WVALID}); end
        for (int k = 2; k <= 4; k++) begin
            nextCycle();
            total++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b100) begin bad++; $display("[TB] FAIL awdly_hold_c%0d got %b want 100", k, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}); end
            total++; if (M_AXI_AWADDR !== 32'h1000_0100) begin bad++; $display("[TB] FAIL awdly_addr_c%0d got %h want 10000100", k, M_AXI_AWADDR); end
        end
        M_AXI_AWREADY = 1'b1;
        nextCycle();
        total++; if ({M_AXI_AWVALID, M_AXI_BREADY, mem_bdone} !== 3'b010) begin bad++; $display("[TB] FAIL awdly_c5 got %b want 010", {M_AXI_AWVALID, M_AXI_BREADY, mem_bdone}); end
        nextCycle();
        M_AXI_BVALID = 1'b0;
        total++; if ({mem_bdone, mem_ready} !== 2'b11) begin bad++; $display("[TB] FAIL awdly_done got %b want 11", {mem_bdone, mem_ready}); end
        nextCycle();
    endtask

    task automatic test_align_and_zero();
        runStore(32'h0000_0043, 32'h1122_3344, 4'h8, 2'b00);
        total++; if (mem_bdone !== 1'b1) begin bad++; $display("[TB] FAIL align_done got %b want 1", mem_bdone); end
        total++; if ({M_AXI_AWADDR, M_AXI_WSTRB} !== {32'h1000_0040, 4'h8}) begin bad++; $display("[TB] FAIL align_addr_strb got %h want 100000408", {M_AXI_AWADDR, M_AXI_WSTRB}); end
        dram_base = 32'hFFFF_FF00;
        runStore(32'h0000_0106, 32'h5555_AAAA, 4'h1, 2'b00);
        total++; if (M_AXI_AWADDR !== 32'h0000_0004) begin bad++; $display("[TB] FAIL wrap_addr got %h want 00000004", M_AXI_AWADDR); end
        dram_base = 32'h1000_0000;
        nextCycle();
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        nextCycle();
        mem_valid = 1'b0;
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, mem_bdone, mem_ready} !== 4'b0011) begin bad++; $display("[TB] FAIL zero_strb_c1 got %b want 0011", {M_AXI_AWVALID, M_AXI_WVALID, mem_bdone, mem_ready}); end
        nextCycle();
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, mem_bdone} !== 3'b000) begin bad++; $display("[TB] FAIL zero_strb_c2 got %b want 000", {M_AXI_AWVALID, M_AXI_WVALID, mem_bdone}); end
    endtask

    task automatic test_errors();
        logic [8:0] expErr;
        runStore(32'h0000_0200, 32'h0000_0001, 4'hF, 2'b10);
        total++; if (mem_bdone !== 1'b1) begin bad++; $display("[TB] FAIL err1_done got %b want 1", mem_bdone); end
        nextCycle();
        runStore(32'h0000_0204, 32'h0000_0002, 4'hF, 2'b11);
        total++; if (mem_bdone !== 1'b1) begin bad++; $display("[TB] FAIL err2_done got %b want 1", mem_bdone); end
        nextCycle();
        runStore(32'h0000_0208, 32'h0000_0003, 4'hF, 2'b01);
        nextCycle();
`ifdef DMEM_AXI_WRITE_ERRSTAT_EN
        expErr = {1'b1, 8'd2};
`else
        expErr = 9'h0;
`endif
        total++; if ({err_sticky, err_count} !== expErr) begin bad++; $display("[TB] FAIL err_stats got %h want %h", {err_sticky, err_count}, expErr); end
    endtask

    task automatic test_reset_mid();
        mem_addr      = 32'h0000_0300;
        mem_wdata     = 32'h0BAD_F00D;
        mem_wstrb     = 4'hF;
        mem_valid     = 1'b1;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        nextCycle();
        mem_valid = 1'b0;
        total++; if (M_AXI_AWVALID !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_pre got %b want 1", M_AXI_AWVALID); end
        #2;
        ARESETN = 1'b0;
        #1;
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, mem_ready} !== 4'b0001) begin bad++; $display("[TB] FAIL rstmid_async got %b want 0001", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, mem_ready}); end
        total++; if ({err_sticky, err_count} !== 9'h0) begin bad++; $display("[TB] FAIL rstmid_err got %h want 0", {err_sticky, err_count}); end
        @(negedge ACLK);
        ARESETN = 1'b1;
        nextCycle();
        total++; if ({mem_ready, M_AXI_AWVALID} !== 2'b10) begin bad++; $display("[TB] FAIL rstmid_after got %b want 10", {mem_ready, M_AXI_AWVALID}); end
        runStore(32'h0000_0044, 32'h1234_5678, 4'hF, 2'b00);
        total++; if (mem_bdone !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_store_done got %b want 1", mem_bdone); end
        total++; if ({M_AXI_AWADDR, M_AXI_WDATA} !== {32'h1000_0044, 32'h1234_5678}) begin bad++; $display("[TB] FAIL rstmid_store_payload got %h", {M_AXI_AWADDR, M_AXI_WDATA}); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        ARESETN       = 1'b0;
        dram_base     = 32'h1000_0000;
        mem_valid     = 1'b0;
        mem_addr      = 32'h0;
        mem_wdata     = 32'h0;
        mem_wstrb     = 4'h0;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BID     = 1'b0;
        M_AXI_BRESP   = 2'b00;
        M_AXI_BVALID  = 1'b0;
        test_reset();
        test_basic();
        test_aw_delay();
        test_align_and_zero();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
